// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and reserved-opcode decode for seq_alu.
// Build option: SEQ_ALU_CARRY_CHAIN_EN turns opcodes 9 (ADC) and 10 (SBB) into real operations.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_MOV = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_BCF = 4'd6;
    localparam logic [3:0] OP_BBF = 4'd7;
    localparam logic [3:0] OP_BUC = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd9;
    localparam logic [3:0] OP_SBB = 4'd10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_reserved(input logic [3:0] op);
`ifdef SEQ_ALU_CARRY_CHAIN_EN
        return op > OP_SBB;
`else
        return op > OP_BUC;
`endif
    endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// Iterative one-bit-per-cycle logical shifter; dir=0 shifts left, dir=1 shifts right.
// done flags the cycle whose clock edge performs the final shift, with data_out holding that value.
module seq_alu_shifter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dir,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] amount,
    output logic [WIDTH-1:0]   data_out,
    output logic               done
);

    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] count;
    logic               dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            count  <= '0;
            dir_q  <= 1'b0;
        end else if (load) begin
            data_q <= data;
            count  <= amount;
            dir_q  <= dir;
        end else if (count != '0) begin
            data_q <= data_out;
            count  <= count - 1'b1;
        end
    end

    assign data_out = dir_q ? (data_q >> 1) : (data_q << 1);
    assign done     = (count == SHAMT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake, persistent carry/borrow/zero flags and flag branches.
// Build option: SEQ_ALU_CARRY_CHAIN_EN adds ADC/SBB using the stored carry/borrow flags as carry-in.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              carry_flag,
    output logic              borrow_flag,
    output logic              zero_flag,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_addr,
    output logic              busy
);

    state_t            state, state_next;
    logic              accept;
    logic              load_beat;
    logic              upd_zero;
    logic [WIDTH-1:0]  res_next;
    logic              taken_next;
    logic [ADDR_W-1:0] baddr_next;
    logic              carry_next, borrow_next, zero_next;
    logic              shift_load, shift_done;
    logic [WIDTH-1:0]  shift_out;
    logic [WIDTH:0]    sum, diff;

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_SHIFT);

    // The extra top bit of sum/diff is carry-out / borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef SEQ_ALU_CARRY_CHAIN_EN
    logic [WIDTH:0] adc_sum, sbb_diff;
    assign adc_sum  = sum  + {{WIDTH{1'b0}}, carry_flag};
    assign sbb_diff = diff - {{WIDTH{1'b0}}, borrow_flag};
`endif

    seq_alu_shifter #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (shift_load),
        .dir     (op == OP_SHR),
        .data    (a),
        .amount  (b[SHAMT_W-1:0]),
        .data_out(shift_out),
        .done    (shift_done)
    );

    always_comb begin
        state_next  = state;
        load_beat   = 1'b0;
        upd_zero    = 1'b0;
        shift_load  = 1'b0;
        res_next    = '0;
        taken_next  = 1'b0;
        baddr_next  = '0;
        carry_next  = carry_flag;
        borrow_next = borrow_flag;
        zero_next   = zero_flag;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_beat = 1'b1;
                    if (!is_reserved(op)) begin
                        case (op)
                            OP_ADD: begin
                                res_next   = sum[WIDTH-1:0];
                                carry_next = sum[WIDTH];
                                upd_zero   = 1'b1;
                            end
                            OP_SUB: begin
                                res_next    = diff[WIDTH-1:0];
                                borrow_next = diff[WIDTH];
                                upd_zero    = 1'b1;
                            end
                            OP_XOR: begin
                                res_next = a ^ b;
                                upd_zero = 1'b1;
                            end
                            OP_MOV: begin
                                res_next = a;
                                upd_zero = 1'b1;
                            end
                            OP_SHL, OP_SHR: begin
                                // A zero amount completes immediately like any single-cycle op.
                                if (b[SHAMT_W-1:0] == '0) begin
                                    res_next = a;
                                    upd_zero = 1'b1;
                                end else begin
                                    load_beat  = 1'b0;
                                    shift_load = 1'b1;
                                    state_next = ST_SHIFT;
                                end
                            end
                            OP_BCF: begin
                                taken_next = carry_flag;
                                baddr_next = addr;
                            end
                            OP_BBF: begin
                                taken_next = borrow_flag;
                                baddr_next = addr;
                            end
                            OP_BUC: begin
                                taken_next = 1'b1;
                                baddr_next = addr;
                            end
`ifdef SEQ_ALU_CARRY_CHAIN_EN
                            OP_ADC: begin
                                res_next   = adc_sum[WIDTH-1:0];
                                carry_next = adc_sum[WIDTH];
                                upd_zero   = 1'b1;
                            end
                            OP_SBB: begin
                                res_next    = sbb_diff[WIDTH-1:0];
                                borrow_next = sbb_diff[WIDTH];
                                upd_zero    = 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    load_beat  = 1'b1;
                    res_next   = shift_out;
                    upd_zero   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (upd_zero) begin
            zero_next = (res_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            branch_addr  <= '0;
            carry_flag   <= 1'b0;
            borrow_flag  <= 1'b0;
            zero_flag    <= 1'b0;
        end else begin
            state       <= state_next;
            carry_flag  <= carry_next;
            borrow_flag <= borrow_next;
            zero_flag   <= zero_next;
            if (load_beat) begin
                out_valid    <= 1'b1;
                result       <= res_next;
                branch_taken <= taken_next;
                branch_addr  <= baddr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8, ADDR_W=4); also covers SEQ_ALU_CARRY_CHAIN_EN builds.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [3:0] addr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_flag, borrow_flag, zero_flag;
    logic       branch_taken;
    logic [3:0] branch_addr;
    logic       busy;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .addr        (addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry_flag  (carry_flag),
        .borrow_flag (borrow_flag),
        .zero_flag   (zero_flag),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Presents one request and returns 1 ns after the edge that accepts it.
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] t);
        int guard = 0;
        op = o; a = x; b = y; addr = t; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++;
        if (guard >= 50) begin
            fails++;
            $display("[TB] FAIL send_timeout op=%0d in_ready stayed %0b, required 1", o, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, result, carry_flag, borrow_flag, zero_flag, branch_taken, branch_addr, busy} !== 18'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got v=%0b r=%h c=%0b b=%0b z=%0b t=%0b ba=%h busy=%0b, required all 0",
                     out_valid, result, carry_flag, borrow_flag, zero_flag, branch_taken, branch_addr, busy);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready got %0b, required 1", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        send(4'd0, 8'h03, 8'h01, 4'd0);
        tests++;
        if ({out_valid, result, carry_flag, zero_flag, branch_taken} !== {1'b1, 8'h04, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL add_basic got v=%0b r=%h c=%0b z=%0b t=%0b, required v=1 r=04 c=0 z=0 t=0",
                     out_valid, result, carry_flag, zero_flag, branch_taken);
        end
    endtask

    task automatic test_flag_branches();
        send(4'd0, 8'hFF, 8'h01, 4'd0);
        tests++;
        if ({out_valid, result, carry_flag, zero_flag} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL add_wrap got v=%0b r=%h c=%0b z=%0b, required v=1 r=00 c=1 z=1",
                     out_valid, result, carry_flag, zero_flag);
        end
        send(4'd6, 8'h00, 8'h00, 4'd5);
        tests++;
        if ({out_valid, result, branch_taken, branch_addr, carry_flag, zero_flag} !==
            {1'b1, 8'h00, 1'b1, 4'd5, 1'b1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL bcf_taken got v=%0b r=%h t=%0b ba=%h c=%0b z=%0b, required v=1 r=00 t=1 ba=5 c=1 z=1",
                     out_valid, result, branch_taken, branch_addr, carry_flag, zero_flag);
        end
        send(4'd7, 8'h00, 8'h00, 4'd9);
        tests++;
        if ({out_valid, branch_taken} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL bbf_not_taken got v=%0b t=%0b, required v=1 t=0", out_valid, branch_taken);
        end
    endtask

    task automatic test_sub_buc();
        send(4'd1, 8'h01, 8'h03, 4'd0);
        tests++;
        if ({result, borrow_flag, zero_flag, carry_flag, branch_taken} !== {8'hFE, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL sub_borrow got r=%h b=%0b z=%0b c=%0b t=%0b, required r=fe b=1 z=0 c=1 t=0",
                     result, borrow_flag, zero_flag, carry_flag, branch_taken);
        end
        send(4'd8, 8'h00, 8'h00, 4'hA);
        tests++;
        if ({branch_taken, branch_addr, result} !== {1'b1, 4'hA, 8'h00}) begin
            fails++;
            $display("[TB] FAIL buc got t=%0b ba=%h r=%h, required t=1 ba=a r=00", branch_taken, branch_addr, result);
        end
        send(4'd7, 8'h00, 8'h00, 4'h3);
        tests++;
        if ({branch_taken, branch_addr} !== {1'b1, 4'h3}) begin
            fails++;
            $display("[TB] FAIL bbf_taken got t=%0b ba=%h, required t=1 ba=3", branch_taken, branch_addr);
        end
    endtask

    task automatic test_shift();
        int cyc = 0;
        int busy_cycles = 0;
        send(4'd4, 8'h03, 8'h03, 4'd0);
        tests++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL shl_start got busy=%0b in_ready=%0b v=%0b, required 1 0 0", busy, in_ready, out_valid);
        end
        while (!out_valid && cyc < 20) begin
            if (busy && !in_ready) busy_cycles++;
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc !== 3 || busy_cycles !== 3) begin
            fails++;
            $display("[TB] FAIL shl_latency got %0d edges, %0d busy cycles, required 3 and 3", cyc, busy_cycles);
        end
        tests++;
        if ({result, busy, zero_flag} !== {8'h18, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL shl_result got r=%h busy=%0b z=%0b, required r=18 busy=0 z=0", result, busy, zero_flag);
        end
        send(4'd5, 8'h80, 8'h00, 4'd0);
        tests++;
        if ({out_valid, result, busy} !== {1'b1, 8'h80, 1'b0}) begin
            fails++;
            $display("[TB] FAIL shr_zero got v=%0b r=%h busy=%0b, required v=1 r=80 busy=0", out_valid, result, busy);
        end
        send(4'd5, 8'h80, 8'h07, 4'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc !== 7 || result !== 8'h01) begin
            fails++;
            $display("[TB] FAIL shr_seven got %0d edges r=%h, required 7 edges r=01", cyc, result);
        end
    endtask

    task automatic test_backpressure();
        send(4'd2, 8'h0F, 8'hFF, 4'd0);
        out_ready = 1'b0;
        tests++;
        if ({out_valid, result, zero_flag} !== {1'b1, 8'hF0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL xor_result got v=%0b r=%h z=%0b, required v=1 r=f0 z=0", out_valid, result, zero_flag);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({out_valid, result, in_ready} !== {1'b1, 8'hF0, 1'b0}) begin
                fails++;
                $display("[TB] FAIL hold_%0d got v=%0b r=%h in_ready=%0b, required v=1 r=f0 in_ready=0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        send(4'd3, 8'h55, 8'h00, 4'd0);
        tests++;
        if ({out_valid, result, branch_taken} !== {1'b1, 8'h55, 1'b0}) begin
            fails++;
            $display("[TB] FAIL mov_overwrite got v=%0b r=%h t=%0b, required v=1 r=55 t=0", out_valid, result, branch_taken);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL drain got v=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_reserved();
        send(4'd0, 8'hFF, 8'h01, 4'd0);
        send(4'd13, 8'h12, 8'h34, 4'd7);
        tests++;
        if ({out_valid, result, branch_taken, carry_flag, zero_flag} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reserved_op got v=%0b r=%h t=%0b c=%0b z=%0b, required v=1 r=00 t=0 c=1 z=1",
                     out_valid, result, branch_taken, carry_flag, zero_flag);
        end
    endtask

    task automatic test_carry_chain();
        send(4'd0, 8'hFF, 8'h01, 4'd0);
        send(4'd9, 8'h01, 8'h01, 4'd0);
`ifdef SEQ_ALU_CARRY_CHAIN_EN
        tests++;
        if ({result, carry_flag, zero_flag} !== {8'h03, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL adc got r=%h c=%0b z=%0b, required r=03 c=0 z=0", result, carry_flag, zero_flag);
        end
        send(4'd1, 8'h00, 8'h01, 4'd0);
        send(4'd10, 8'h05, 8'h02, 4'd0);
        tests++;
        if ({result, borrow_flag, zero_flag} !== {8'h02, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL sbb got r=%h b=%0b z=%0b, required r=02 b=0 z=0", result, borrow_flag, zero_flag);
        end
`else
        tests++;
        if ({out_valid, result, carry_flag, zero_flag} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL op9_reserved got v=%0b r=%h c=%0b z=%0b, required v=1 r=00 c=1 z=1",
                     out_valid, result, carry_flag, zero_flag);
        end
`endif
    endtask

    task automatic test_reset_mid_shift();
        int stale = 0;
        send(4'd1, 8'h00, 8'h01, 4'd0);
        send(4'd4, 8'h01, 8'h07, 4'd0);
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_shift_busy got %0b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, result, carry_flag, borrow_flag, zero_flag, branch_taken, branch_addr, busy} !== 18'd0) begin
            fails++;
            $display("[TB] FAIL mid_shift_reset got v=%0b r=%h c=%0b b=%0b z=%0b t=%0b ba=%h busy=%0b, required all 0",
                     out_valid, result, carry_flag, borrow_flag, zero_flag, branch_taken, branch_addr, busy);
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) stale++;
        end
        tests++;
        if (stale !== 0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL post_reset got %0d stale cycles in_ready=%0b, required 0 and 1", stale, in_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 4'd0; a = 8'd0; b = 8'd0; addr = 4'd0;
        test_reset();
        test_add();
        test_flag_branches();
        test_sub_buc();
        test_shift();
        test_backpressure();
        test_reserved();
        test_carry_chain();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
